// File: rtl/fx_ci_pkg.sv
// Shared types and constants for the f(x) custom-instruction stream master.
// Build with CI_TIMEOUT_EN to add the WAIT watchdog and the sticky err flag.
package fx_ci_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } ci_state_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fx_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty are registered and
// computed from the next-state pointers so they are valid from reset onward.
module fx_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // Same index with differing wrap bits means the write side lapped the read side.
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/fx_ci_master.sv
// Streams float32 samples through a multi-cycle Nios II custom-instruction slave,
// one transaction at a time. Define CI_TIMEOUT_EN to abort stalled WAITs with a qNaN.
module fx_ci_master
    import fx_ci_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        ci_clk_en,
    output logic        ci_start,
    output logic [31:0] ci_dataa,
    input  logic        ci_done,
    input  logic [31:0] ci_result,
    output logic        busy,
    output logic        err
);

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;

    ci_state_t   state_q, state_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_data_q, m_data_d;
    logic        ci_clk_en_q, ci_clk_en_d;
    logic        ci_start_q, ci_start_d;
    logic [31:0] ci_dataa_q, ci_dataa_d;

`ifdef CI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
`endif

    assign fifo_push = s_valid && !fifo_full;
    assign fifo_pop  = (state_q == ISSUE);

    fx_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (s_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        ci_dataa_d = ci_dataa_q;
`ifdef CI_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !m_valid_q) begin
                    state_d    = ISSUE;
                    ci_dataa_d = fifo_head;
                end
            end
            ISSUE: begin
                // A done seen while start is still high belongs to nobody; it is ignored.
                state_d = WAIT;
`ifdef CI_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (ci_done) begin
                    m_data_d  = ci_result;
                    m_valid_d = 1'b1;
                    state_d   = HOLD;
                end
`ifdef CI_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    m_data_d  = FP_QNAN;
                    m_valid_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                end
`endif
            end
            HOLD: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Enable and start are decoded from the next state so they rise together.
        ci_start_d  = (state_d == ISSUE);
        ci_clk_en_d = (state_d == ISSUE) || (state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            m_valid_q   <= 1'b0;
            m_data_q    <= FP_ZERO;
            ci_clk_en_q <= 1'b0;
            ci_start_q  <= 1'b0;
            ci_dataa_q  <= '0;
`ifdef CI_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            ci_clk_en_q <= ci_clk_en_d;
            ci_start_q  <= ci_start_d;
            ci_dataa_q  <= ci_dataa_d;
`ifdef CI_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign s_ready   = !fifo_full;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign ci_clk_en = ci_clk_en_q;
    assign ci_start  = ci_start_q;
    assign ci_dataa  = ci_dataa_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

`ifdef CI_TIMEOUT_EN
    assign err = err_q;
`else
    // Without the watchdog TIMEOUT has no effect; this folds to a constant 0.
    assign err = (TIMEOUT < 0);
`endif

endmodule
